instr_fetch_queue: RTL and testbench

Instruction fetch stage that sits directly downstream of the program counter. It takes the PC value as a redirect target, streams sequential word fetches (PC, PC+4, …) to instruction memory over a valid/ready request channel, and buffers in-order responses in a small queue. Instructions are presented to decode with their PC under a valid/ready handshake. A redirect flushes the queue and drops any stale in-flight responses.

---
 rtl/instr_fetch_queue.sv | 248 ++++++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue
//
// Purpose:
//   Instruction fetch stage placed directly after the program counter. A
//   redirect loads a new fetch target. The stage then streams sequential word
//   fetches (PC, PC+4, ...) to instruction memory over a valid/ready request
//   channel. In-order responses are buffered in a small queue, and each
//   instruction is presented to decode with its PC under a valid/ready
//   handshake. A redirect flushes the queue and arranges for every response
//   still in flight to be dropped when it arrives.
//
// Parameters:
//   DEPTH     - queue entries, and also the maximum number of outstanding
//               memory requests (power of two, >= 2)
//   RESET_PC  - fetch address used after reset
//
// Ports:
//   clk             in   single clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   fetch_en        in   allows new memory requests to issue
//   redirect        in   1-cycle pulse: flush and restart fetch at pc_in
//   pc_in   [31:0]  in   redirect target
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   response beat (in order, no backpressure)
//   imem_rsp_data   in   instruction word
//   inst_valid      out  queue head valid
//   inst_ready      in   decode accepts the head
//   inst_data [31:0] out head instruction
//   inst_pc   [31:0] out PC of the head instruction
//   misalign_err    out  sticky misaligned-redirect flag
//                        (exists only when IFQ_MISALIGN_CHECK_EN is defined)
//
// Configuration macro:
//   IFQ_MISALIGN_CHECK_EN - when defined, a redirect to a target that is not
//   word aligned sets misalign_err and parks the fetch FSM in IDLE until
//   fetch_en is deasserted and then reasserted. When undefined, pc_in[1:0]
//   is ignored.
// ============================================================================
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] pc_in,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    // Counter width covers the range 0..DEPTH inclusive. Queue pointers wrap
    // naturally because DEPTH is a power of two.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];

    logic          w_slot_avail;
    logic          w_req_fire;
    logic          w_req_stalled;
    logic          w_rsp_acc;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_start_blocked;
    logic [31:0]   w_target;
    logic [CW-1:0] w_outstanding_next;

    // ------------------------------------------------------------------------
    // Request channel and handshake decode
    // ------------------------------------------------------------------------

    // A request may issue only if the queue can hold its response. The queue
    // entries and the responses still in flight together must stay below
    // DEPTH, so every issued request already owns a slot.
    assign w_slot_avail   = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_S;
    assign imem_req_valid = (r_state == FETCH) && w_slot_avail;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_req_stalled  = imem_req_valid && !imem_req_ready;

    // A beat that arrives while nothing is outstanding has no reserved slot.
    // It is a protocol error and is ignored completely.
    assign w_rsp_acc  = imem_rsp_valid && (r_outstanding != '0);
    assign w_rsp_drop = w_rsp_acc && (r_discard != '0);
    assign w_push     = w_rsp_acc && (r_discard == '0);

    // The decode handshake is masked during a redirect cycle, so a flush
    // never races a pop.
    assign inst_valid = (r_count != '0) && !redirect;
    assign w_pop      = inst_valid && inst_ready;
    assign inst_data  = r_q_data[r_rd_ptr];
    assign inst_pc    = r_q_pc[r_rd_ptr];

    assign w_target           = {pc_in[31:2], 2'b00};
    assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_acc);

`ifdef IFQ_MISALIGN_CHECK_EN
    logic r_misalign_hold;
    logic w_misalign;

    assign w_misalign      = redirect && (pc_in[1:0] != 2'b00);
    assign w_start_blocked = r_misalign_hold;
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^pc_in[1:0];
    assign w_start_blocked = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------------

    // IDLE/FETCH control. Leaving FETCH waits until no request is stalled
    // mid-handshake, so a valid request is never withdrawn because fetch_en
    // dropped. A misaligned redirect, when the check is built in, parks the
    // FSM in IDLE and holds it there until fetch_en has been deasserted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
`ifdef IFQ_MISALIGN_CHECK_EN
            r_misalign_hold <= 1'b0;
            misalign_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_en && !w_start_blocked) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!fetch_en && !w_req_stalled) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef IFQ_MISALIGN_CHECK_EN
            if (w_misalign) begin
                r_state         <= IDLE;
                r_misalign_hold <= 1'b1;
                misalign_err    <= 1'b1;
            end else if (!fetch_en) begin
                r_misalign_hold <= 1'b0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Addresses, counters and queue pointers
    // ------------------------------------------------------------------------

    // A redirect overrides every other update. After a redirect, each request
    // still in flight is stale. That includes a request that handshakes in the
    // redirect cycle itself. It excludes a response consumed in that cycle,
    // whether the response was pushed or dropped. The stale count is therefore
    // exactly the next outstanding count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= w_target;
            r_rsp_pc      <= w_target;
            r_count       <= '0;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_outstanding_next;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= w_outstanding_next;
            if (w_rsp_drop) begin
                r_discard <= r_discard - CNT_ONE;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // ------------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------------

    // Queue storage. Every entry is reset, so the head reads as zero out of
    // reset. A beat that arrives in a redirect cycle is stale and is not
    // written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (w_push && !redirect) begin
            r_q_data[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// tb_instr_fetch_queue
//
// Self-checking bench for instr_fetch_queue (DEPTH=4).
//
// Memory model:
//   - Accepts requests with a programmable ready and latency.
//   - Returns addr ^ 32'hA5A5_0000 in order.
//
// Scoreboard:
//   - Every non-stale response beat pushes its expected {pc, data}.
//   - Each decode pop is compared against the front entry.
//
// Reference model:
//   - A separate address model checks each request address.
//
// Test phases:
//   - A per-cycle table covers start-up and backpressure.
//   - Hand-written sequences cover redirects, simultaneous events,
//     wrap-around, misalignment and asynchronous reset.
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] pc_in;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef IFQ_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect       (redirect),
        .pc_in          (pc_in),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef IFQ_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } memReq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } expInst_t;

    typedef struct {
        bit          fe;
        bit          ir;
        bit          expReqValid;
        logic [31:0] expReqAddr;
        bit          expInstValid;
    } vec_t;

    memReq_t  pend[$];
    expInst_t sb[$];
    vec_t     vecs[12];

    // Per-cycle stimulus knobs
    bit          fe;
    bit          ir;
    bit          rd;
    logic [31:0] pcIn;
    bit          memReady;
    int          lat;

    // Model state
    int          cyc;
    int          epoch;
    logic [31:0] nextAddr;
    bit          holdPend;
    logic [31:0] holdAddr;

    // Values sampled in the last cycle
    bit          sReqValid;
    logic [31:0] sReqAddr;
    bit          sInstValid;
    bit          popped;
    logic [31:0] poppedPc;
    bit          fired;
    logic [31:0] firedAddr;

    int passed;
    int total;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        $display("[TB] FAIL %s: timed out waiting, got no event expected one", name);
    endtask

    // Drives one clock cycle. Inputs change on the falling edge; outputs are
    // sampled 1 time unit later, well before the next rising edge.
    task automatic applyStimulus();
        memReq_t  r;
        memReq_t  rq;
        expInst_t e;
        bit       rspNow;

        @(negedge clk);
        fetch_en       = fe;
        inst_ready     = ir;
        redirect       = rd;
        pc_in          = pcIn;
        imem_req_ready = memReady;
        rspNow         = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r              = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = r.addr ^ XOR_KEY;
            rspNow         = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        sReqValid  = imem_req_valid;
        sReqAddr   = imem_req_addr;
        sInstValid = inst_valid;

        if (holdPend) begin
            checkOutput("req_valid_hold", {31'b0, imem_req_valid}, 32'd1);
            checkOutput("req_addr_hold", imem_req_addr, holdAddr);
        end

        fired = imem_req_valid && imem_req_ready;
        if (fired) begin
            firedAddr = imem_req_addr;
            checkOutput("req_addr", imem_req_addr, nextAddr);
            nextAddr = nextAddr + 32'd4;
            rq.addr  = imem_req_addr;
            rq.epoch = epoch;
            rq.due   = cyc + lat;
            pend.push_back(rq);
        end

        popped = 1'b0;
        if (rd) begin
            checkOutput("redirect_inst_valid", {31'b0, inst_valid}, 32'd0);
            nextAddr = {pcIn[31:2], 2'b00};
            sb.delete();
            epoch++;
        end else begin
            checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, (sb.size() != 0)});
            if (inst_valid && inst_ready && sb.size() > 0) begin
                popped   = 1'b1;
                poppedPc = inst_pc;
                e = sb.pop_front();
                checkOutput("inst_pc", inst_pc, e.pc);
                checkOutput("inst_data", inst_data, e.data);
            end
            if (rspNow && r.epoch == epoch) begin
                e.pc   = r.addr;
                e.data = r.addr ^ XOR_KEY;
                sb.push_back(e);
            end
        end

        holdPend = imem_req_valid && !imem_req_ready && !rd;
        holdAddr = imem_req_addr;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        int popCount;
        logic [31:0] wrapAddr[2];
        int nWrap;

        // Start-up and backpressure: one row per cycle.
        // Fields: fetch_en, inst_ready, req_valid, req_addr, inst_valid.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1};

        passed   = 0;
        total    = 0;
        cyc      = 0;
        epoch    = 0;
        nextAddr = RESET_PC;
        holdPend = 1'b0;
        fe = 1'b0; ir = 1'b0; rd = 1'b0; pcIn = 32'h0; memReady = 1'b1; lat = 1;

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect       = 1'b0;
        pc_in          = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        #3;
        checkOutput("reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("reset_req_addr", imem_req_addr, RESET_PC);
        checkOutput("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("reset_inst_data", inst_data, 32'd0);
        checkOutput("reset_inst_pc", inst_pc, 32'd0);
`ifdef IFQ_MISALIGN_CHECK_EN
        checkOutput("reset_misalign_err", {31'b0, misalign_err}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table-driven start-up and backpressure");
        for (int i = 0; i < 12; i++) begin
            fe = vecs[i].fe;
            ir = vecs[i].ir;
            applyStimulus();
            checkOutput($sformatf("tbl%0d_req_valid", i), {31'b0, sReqValid}, {31'b0, vecs[i].expReqValid});
            checkOutput($sformatf("tbl%0d_req_addr", i), sReqAddr, vecs[i].expReqAddr);
            checkOutput($sformatf("tbl%0d_inst_valid", i), {31'b0, sInstValid}, {31'b0, vecs[i].expInstValid});
        end

        $display("[TB] sustained throughput");
        popCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            if (popped) popCount++;
        end
        checkOutput("throughput_pops", 32'(popCount), 32'd16);

        $display("[TB] redirect with two outstanding requests");
        memReady = 1'b0;
        lat      = 3;
        for (int i = 0; i < 6; i++) applyStimulus();
        memReady = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus();
        memReady = 1'b0;
        rd = 1'b1; pcIn = 32'h0000_0100;
        applyStimulus();
        rd = 1'b0; memReady = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            applyStimulus();
            if (popped) got = 1'b1;
        end
        if (got) checkOutput("redirect_first_pc", poppedPc, 32'h0000_0100);
        else timeoutFail("redirect_first_pc");

        $display("[TB] redirect with simultaneous request and response");
        lat = 1;
        for (int i = 0; i < 6; i++) applyStimulus();
        rd = 1'b1; pcIn = 32'h0000_0200;
        applyStimulus();
        checkOutput("simul_req_valid", {31'b0, sReqValid}, 32'd1);
        rd = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            applyStimulus();
            if (popped) got = 1'b1;
        end
        if (got) checkOutput("simul_first_pc", poppedPc, 32'h0000_0200);
        else timeoutFail("simul_first_pc");

        $display("[TB] address wrap-around");
        rd = 1'b1; pcIn = 32'hFFFF_FFFC;
        applyStimulus();
        rd = 1'b0;
        nWrap = 0;
        for (int i = 0; i < 20 && nWrap < 2; i++) begin
            applyStimulus();
            if (fired) begin
                wrapAddr[nWrap] = firedAddr;
                nWrap++;
            end
        end
        if (nWrap == 2) begin
            checkOutput("wrap_addr0", wrapAddr[0], 32'hFFFF_FFFC);
            checkOutput("wrap_addr1", wrapAddr[1], 32'h0000_0000);
        end else begin
            timeoutFail("wrap_addr");
        end
        for (int i = 0; i < 6; i++) applyStimulus();

        $display("[TB] misaligned redirect");
        rd = 1'b1; pcIn = 32'h0000_0102;
        applyStimulus();
        rd = 1'b0;
`ifdef IFQ_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("misalign_req_valid", {31'b0, sReqValid}, 32'd0);
            checkOutput("misalign_err", {31'b0, misalign_err}, 32'd1);
        end
        fe = 1'b0;
        applyStimulus();
        fe = 1'b1;
`endif
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus();
            if (fired) got = 1'b1;
        end
        if (got) checkOutput("misalign_next_addr", firedAddr, 32'h0000_0100);
        else timeoutFail("misalign_next_addr");

        $display("[TB] asynchronous reset mid-stream");
        ir = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("midreset_req_addr", imem_req_addr, RESET_PC);
        checkOutput("midreset_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("midreset_inst_data", inst_data, 32'd0);
        checkOutput("midreset_inst_pc", inst_pc, 32'd0);
`ifdef IFQ_MISALIGN_CHECK_EN
        checkOutput("midreset_misalign_err", {31'b0, misalign_err}, 32'd0);
`endif
        imem_rsp_valid = 1'b0;
        redirect       = 1'b0;
        pend.delete();
        sb.delete();
        holdPend = 1'b0;
        nextAddr = RESET_PC;
        epoch++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ir = 1'b1; fe = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus();
            if (fired) got = 1'b1;
        end
        if (got) checkOutput("postreset_first_addr", firedAddr, RESET_PC);
        else timeoutFail("postreset_first_addr");
        for (int i = 0; i < 8; i++) applyStimulus();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
